// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC, instruction-memory request/ack, 2-deep fetch queue, redirect
// Optional FETCH_ALIGN_CHECK_EN: halt on misaligned branch target.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemRdata,
    output logic        o_instrValid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_instrReady,
    input  logic        i_branchTaken,
    input  logic [31:0] i_branchTarget,
    output logic        o_misalignedFetch
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] next_pc, next_pc_nxt;
    logic [31:0] q_instr0, q_instr1, q_instr0_nxt, q_instr1_nxt;
    logic [31:0] q_pc0, q_pc1, q_pc0_nxt, q_pc1_nxt;
    logic [1:0]  count, count_nxt, count_after_pop;
    logic        misaligned, misaligned_nxt;

    logic        pop;
    logic        redirect;
    logic        fetch_ack;
    logic        push;
    logic        bad_target;
    logic [31:0] target;

    assign pop       = (count != 2'd0) && i_instrReady;
    assign redirect  = pop && i_branchTaken;
    assign fetch_ack = (state == S_FETCH) && i_imemAck;
    assign push      = fetch_ack;
    assign target    = {i_branchTarget[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign bad_target = redirect && (i_branchTarget[1:0] != 2'b00);
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^i_branchTarget[1:0];
    assign bad_target         = 1'b0;
`endif

    assign o_imemReq         = (state == S_FETCH) || (state == S_DRAIN);
    assign o_imemAddr        = req_addr;
    assign o_instrValid      = (count != 2'd0);
    assign o_instr           = q_instr0;
    assign o_pc              = q_pc0;
    assign o_misalignedFetch = misaligned;

    // Queue: pop shifts first, then push lands in the first free slot.
    always_comb begin
        q_instr0_nxt    = q_instr0;
        q_instr1_nxt    = q_instr1;
        q_pc0_nxt       = q_pc0;
        q_pc1_nxt       = q_pc1;
        count_after_pop = count - {1'b0, pop};
        if (pop) begin
            q_instr0_nxt = q_instr1;
            q_pc0_nxt    = q_pc1;
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                q_instr0_nxt = i_imemRdata;
                q_pc0_nxt    = req_addr;
            end else begin
                q_instr1_nxt = i_imemRdata;
                q_pc1_nxt    = req_addr;
            end
        end
        count_nxt = count_after_pop + {1'b0, push};
        if (redirect) begin
            count_nxt = 2'd0;
        end
    end

    always_comb begin
        state_nxt      = state;
        req_addr_nxt   = req_addr;
        next_pc_nxt    = next_pc;
        misaligned_nxt = misaligned;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (redirect) begin
                    if (bad_target) begin
                        misaligned_nxt = 1'b1;
                        state_nxt      = i_imemAck ? S_HALT : S_DRAIN;
                    end else if (i_imemAck) begin
                        next_pc_nxt  = target;
                        req_addr_nxt = target;
                    end else begin
                        next_pc_nxt = target;
                        state_nxt   = S_DRAIN;
                    end
                end else if (fetch_ack) begin
                    req_addr_nxt = req_addr + 32'd4;
                    next_pc_nxt  = req_addr + 32'd4;
                    if (count_nxt == 2'd2) begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (pop) begin
                    state_nxt = S_FETCH;
                    if (bad_target) begin
                        misaligned_nxt = 1'b1;
                        state_nxt      = S_HALT;
                    end else if (redirect) begin
                        next_pc_nxt  = target;
                        req_addr_nxt = target;
                    end
                end
            end
            S_DRAIN: begin
                // Stale response is dropped; only then may the target be requested.
                if (i_imemAck) begin
                    if (misaligned) begin
                        state_nxt = S_HALT;
                    end else begin
                        req_addr_nxt = next_pc;
                        state_nxt    = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state      <= S_IDLE;
            req_addr   <= RESET_PC;
            next_pc    <= RESET_PC;
            q_instr0   <= 32'd0;
            q_instr1   <= 32'd0;
            q_pc0      <= 32'd0;
            q_pc1      <= 32'd0;
            count      <= 2'd0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_addr   <= req_addr_nxt;
            next_pc    <= next_pc_nxt;
            q_instr0   <= q_instr0_nxt;
            q_instr1   <= q_instr1_nxt;
            q_pc0      <= q_pc0_nxt;
            q_pc1      <= q_pc1_nxt;
            count      <= count_nxt;
            misaligned <= misaligned_nxt;
        end
    end

endmodule

`default_nettype wire
